// File: rtl/m_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// m_serial_adder_pkg
// Shared definitions for the bit-serial adder: the sequencer state width and
// state encoding (IDLE=0, RUN=1, DONE=2).
// ---------------------------------------------------------------------------
package m_serial_adder_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : m_serial_adder_pkg

// File: rtl/m_serial_adder_if.sv
// ---------------------------------------------------------------------------
// m_serial_adder_if
// Operand and result handshakes of the bit-serial adder.
//   w_in_valid / w_in_ready : operand handshake, carries w_a, w_b
//                             (and w_sub when SERIAL_ADDER_SUB_EN is defined)
//   w_out_valid / w_out_ready : result handshake, carries w_sum, w_cout
// Modports:
//   master : operand producer / result consumer
//   slave  : the adder itself
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the w_sub signal).
// ---------------------------------------------------------------------------
interface m_serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             w_in_valid;
  logic             w_in_ready;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_out_valid;
  logic             w_out_ready;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             w_sub;

  modport master (
    output w_in_valid, w_a, w_b, w_sub, w_out_ready,
    input  w_in_ready, w_out_valid, w_sum, w_cout
  );

  modport slave (
    input  w_in_valid, w_a, w_b, w_sub, w_out_ready,
    output w_in_ready, w_out_valid, w_sum, w_cout
  );
`else
  modport master (
    output w_in_valid, w_a, w_b, w_out_ready,
    input  w_in_ready, w_out_valid, w_sum, w_cout
  );

  modport slave (
    input  w_in_valid, w_a, w_b, w_out_ready,
    output w_in_ready, w_out_valid, w_sum, w_cout
  );
`endif

endinterface : m_serial_adder_if

// File: rtl/m_HA.sv
// ---------------------------------------------------------------------------
// m_HA
// Half-adder primitive.
// Ports:
//   i_a, i_b : input bits
//   o_s      : sum bit   (i_a ^ i_b)
//   o_c      : carry bit (i_a & i_b)
// ---------------------------------------------------------------------------
module m_HA (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule : m_HA

// File: rtl/m_full_adder.sv
// ---------------------------------------------------------------------------
// m_full_adder
// Combinational full adder built from two half adders; the two half-adder
// carries can never both be 1, so an OR merges them into the carry out.
// Ports:
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_s      : sum bit
//   o_c      : carry out
// ---------------------------------------------------------------------------
module m_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_c
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  m_HA u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  m_HA u_ha1 (
    .i_a (w_s0),
    .i_b (i_cin),
    .o_s (o_s),
    .o_c (w_c1)
  );

  assign o_c = w_c0 | w_c1;

endmodule : m_full_adder

// File: rtl/m_serial_adder.sv
// ---------------------------------------------------------------------------
// m_serial_adder
// Bit-serial adder: operands are accepted in parallel, then added one bit per
// clock (LSB first) through a single full adder with a carry flip-flop between
// steps. The WIDTH-bit sum and carry-out are presented on a result handshake.
// Accept edge T -> w_out_valid from T+WIDTH; one addition per WIDTH+2 cycles
// with w_out_ready held high.
// Parameters:
//   WIDTH : operand / sum width, 1..32
// Ports:
//   w_clk   : clock, rising edge
//   w_rst_n : asynchronous active-low reset
//   bus     : m_serial_adder_if.slave (operand and result handshakes)
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, bus.w_sub=1 at the accept edge turns the operation into
//   w_a - w_b (B inverted, carry seeded with 1); w_cout=1 means no borrow.
// ---------------------------------------------------------------------------
module m_serial_adder
  import m_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           w_clk,
  input  logic           w_rst_n,
  m_serial_adder_if.slave bus
);

  // Extra counter bit keeps WIDTH=1 (and powers of two) representable.
  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH:0]   w_sum_cat;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_unused_lsb;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_init;
  logic             w_in_ready;
  logic             w_out_valid;

  m_full_adder u_fa (
    .i_a   (r_a_sr[0]),
    .i_b   (r_b_sr[0]),
    .i_cin (r_carry),
    .o_s   (w_fa_s),
    .o_c   (w_fa_c)
  );

  // Right shift of the sum register with the new bit entering at the top;
  // the bit falling off the bottom is never needed.
  assign w_sum_cat    = {w_fa_s, r_sum_sr};
  assign w_sum_next   = w_sum_cat[WIDTH:1];
  assign w_unused_lsb = w_sum_cat[0];

  assign w_accept = (r_state == ST_IDLE) && bus.w_in_valid;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST_CNT);

`ifdef SERIAL_ADDER_SUB_EN
  // Two's complement subtraction: a + ~b + 1.
  assign w_b_load     = bus.w_sub ? ~bus.w_b : bus.w_b;
  assign w_carry_init = bus.w_sub;
`else
  assign w_b_load     = bus.w_b;
  assign w_carry_init = 1'b0;
`endif

  // State register
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.w_in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)          w_next = ST_DONE;
      ST_DONE: if (bus.w_out_ready) w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready  = 1'b1;
      ST_DONE: w_out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.w_in_ready  = w_in_ready;
  assign bus.w_out_valid = w_out_valid;
  assign bus.w_sum       = r_sum;
  assign bus.w_cout      = r_cout;

  // Serial datapath. r_sum/r_cout are separate result registers so the
  // outputs hold still while the next operation shifts through r_sum_sr.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr  <= bus.w_a;
      r_b_sr  <= w_b_load;
      r_carry <= w_carry_init;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= w_sum_next;
      r_carry  <= w_fa_c;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_fa_c;
      end
    end
  end

endmodule : m_serial_adder
